// File: rtl/gnw_pixel_pipe.sv
// Pixel pipe: fetches one artwork word per window pixel, composites latched segment masks over grey.
// Latency: RD_LAT+2 cycles from hpos/vpos/sync/blank inputs to rgb/sync/blank outputs.
// Backpressure: none; free-running raster, memory must answer every read in exactly RD_LAT cycles.
module gnw_pixel_pipe #(
    parameter int          IMG_W   = 720,
    parameter int          IMG_H   = 540,
    parameter int          X_OFF   = 40,
    parameter int          Y_OFF   = 30,
    parameter int          AW      = 19,
    parameter int          RD_LAT  = 2,
    parameter logic [23:0] BORDER  = 24'h000000,
    parameter logic [23:0] SEG_RGB = 24'h202020
) (
    input  logic          clk_vid,
    input  logic          rst_n,
    input  logic [10:0]   hpos,
    input  logic [9:0]    vpos,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          hblank_in,
    input  logic          vblank_in,
    input  logic [127:0]  seg_on,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [15:0]   mem_data,
    output logic [23:0]   rgb,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank
);

    typedef enum logic {WAIT_SOF, RUN} state_t;

    typedef struct packed {
        logic win;
        logic act;
        logic hs;
        logic vs;
        logic hb;
        logic vb;
    } flag_t;

    localparam flag_t       IDLE = '{win: 1'b0, act: 1'b0, hs: 1'b1, vs: 1'b1, hb: 1'b1, vb: 1'b1};
    localparam logic [10:0] X_LO = 11'(X_OFF);
    localparam logic [10:0] X_HI = 11'(X_OFF + IMG_W - 1);
    localparam logic [9:0]  Y_LO = 10'(Y_OFF);
    localparam logic [9:0]  Y_HI = 10'(Y_OFF + IMG_H - 1);

    state_t               state;
    logic [AW-1:0]        cnt;
    logic [127:0]         seg_lat;
    logic                 vblank_q;
    flag_t [RD_LAT:0]     pipe;
    flag_t                cur;
    flag_t                last;
    logic                 sof;
    logic                 go;
    logic                 win;
    logic                 act;

    always_comb begin
        sof  = (hpos == 11'd0) && (vpos == 10'd0);
        go   = (state == RUN) || sof;
        win  = (hpos >= X_LO) && (hpos <= X_HI) && (vpos >= Y_LO) && (vpos <= Y_HI);
        act  = !hblank_in && !vblank_in;
        // Before the first start-of-frame, inactive flags flow down the pipe so outputs stay idle
        cur  = go ? '{win: win, act: act, hs: hsync_in, vs: vsync_in, hb: hblank_in, vb: vblank_in}
                  : IDLE;
        last = pipe[RD_LAT];
    end

    always_ff @(posedge clk_vid) begin
        if (!rst_n) begin
            state    <= WAIT_SOF;
            cnt      <= '0;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            seg_lat  <= '0;
            vblank_q <= 1'b1;
            pipe     <= {(RD_LAT + 1){IDLE}};
            rgb      <= 24'h0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            hblank   <= 1'b1;
            vblank   <= 1'b1;
        end else begin
            if (sof)
                state <= RUN;

            // Segment state is sampled once per frame at vblank start so a frame never tears
            vblank_q <= vblank_in;
            if (vblank_in && !vblank_q)
                seg_lat <= seg_on;

            mem_rd <= go && win;
            if (go) begin
                if (win) begin
                    mem_addr <= sof ? '0 : cnt;
                    cnt      <= sof ? AW'(1) : cnt + AW'(1);
                end else if (sof) begin
                    cnt <= '0;
                end
            end

            pipe <= {pipe[RD_LAT-1:0], cur};

            hsync  <= last.hs;
            vsync  <= last.vs;
            hblank <= last.hb;
            vblank <= last.vb;
            if (!last.act)
                rgb <= 24'h0;
            else if (!last.win)
                rgb <= BORDER;
            else if (mem_data[15] && seg_lat[mem_data[14:8]])
                rgb <= SEG_RGB;
            else
                rgb <= {3{mem_data[7:0]}};
        end
    end

endmodule

// File: tb/tb_gnw_pixel_pipe.sv
// Bench for gnw_pixel_pipe on a shrunken raster, checked cycle by cycle against a raster-level model.
module tb_gnw_pixel_pipe;

    localparam int IMG_W  = 6;
    localparam int IMG_H  = 4;
    localparam int X_OFF  = 3;
    localparam int Y_OFF  = 2;
    localparam int AW     = 5;
    localparam int RD_LAT = 3;
    localparam int LAT    = RD_LAT + 2;
    localparam int H_ACT  = 12;
    localparam int H_TOT  = 18;
    localparam int V_ACT  = 8;
    localparam int V_TOT  = 10;
    localparam int FR     = H_TOT * V_TOT;
    localparam logic [23:0] BORDER  = 24'h0000A0;
    localparam logic [23:0] SEG_RGB = 24'h202020;

    logic          clk_vid = 1'b0;
    logic          rst_n;
    logic [10:0]   hpos;
    logic [9:0]    vpos;
    logic          hsync_in, vsync_in, hblank_in, vblank_in;
    logic [127:0]  seg_on;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [15:0]   mem_data;
    logic [23:0]   rgb;
    logic          hsync, vsync, hblank, vblank;

    gnw_pixel_pipe #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .X_OFF(X_OFF), .Y_OFF(Y_OFF), .AW(AW),
        .RD_LAT(RD_LAT), .BORDER(BORDER), .SEG_RGB(SEG_RGB)
    ) dut (
        .clk_vid(clk_vid), .rst_n(rst_n), .hpos(hpos), .vpos(vpos),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblank_in(hblank_in), .vblank_in(vblank_in),
        .seg_on(seg_on), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .rgb(rgb), .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank)
    );

    always #5 clk_vid = ~clk_vid;

    // Image memory with a fixed RD_LAT-cycle read pipeline
    logic [15:0] mem [2**AW];
    logic [15:0] rdp [RD_LAT];
    always @(posedge clk_vid) begin
        rdp[0] <= mem_rd ? mem[mem_addr] : 16'h0;
        for (int i = 1; i < RD_LAT; i++)
            rdp[i] <= rdp[i-1];
    end
    assign mem_data = rdp[RD_LAT-1];

    typedef struct {
        logic [23:0] rgb;
        logic        hs, vs, hb, vb;
    } exp_t;

    exp_t          q[$];
    int            total = 0;
    int            bad   = 0;
    int            pos;
    bit            running;
    logic          vb_prev;
    logic [127:0]  seg_model;
    logic          rd_e;
    logic [AW-1:0] addr_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int hof(input int p);
        return p % H_TOT;
    endfunction

    function automatic int vof(input int p);
        return (p / H_TOT) % V_TOT;
    endfunction

    task automatic step();
        int   h, v, a;
        bit   w, act;
        exp_t e, o;
        logic [15:0] word;
        h = hof(pos);
        v = vof(pos);
        hpos      = 11'(h);
        vpos      = 10'(v);
        hblank_in = (h >= H_ACT);
        vblank_in = (v >= V_ACT);
        hsync_in  = !(h >= H_ACT + 1 && h < H_ACT + 4);
        vsync_in  = (v != V_ACT + 1);
        w   = (h >= X_OFF) && (h < X_OFF + IMG_W) && (v >= Y_OFF) && (v < Y_OFF + IMG_H);
        act = !hblank_in && !vblank_in;
        a   = (v - Y_OFF) * IMG_W + (h - X_OFF);

        e = '{rgb: 24'h0, hs: 1'b1, vs: 1'b1, hb: 1'b1, vb: 1'b1};
        if (!rst_n) begin
            running   = 0;
            seg_model = '0;
            vb_prev   = 1'b1;
            rd_e      = 1'b0;
            addr_e    = '0;
            foreach (q[i]) q[i] = e;
        end else begin
            if (vblank_in && !vb_prev) seg_model = seg_on;
            vb_prev = vblank_in;
            if (h == 0 && v == 0) running = 1;
            rd_e = running && w;
            if (rd_e) addr_e = AW'(a);
            if (running) begin
                e.hs = hsync_in; e.vs = vsync_in; e.hb = hblank_in; e.vb = vblank_in;
                if (!act)
                    e.rgb = 24'h0;
                else if (!w)
                    e.rgb = BORDER;
                else begin
                    word = mem[a];
                    e.rgb = (word[15] && seg_model[word[14:8]]) ? SEG_RGB : {3{word[7:0]}};
                end
            end
        end
        q.push_back(e);

        @(posedge clk_vid);
        #1;
        chk("mem_rd", {31'b0, mem_rd}, {31'b0, rd_e});
        chk("mem_addr", 32'(mem_addr), 32'(addr_e));
        if (rd_e && h == X_OFF && v == Y_OFF)
            chk("addr_first", 32'(mem_addr), 32'd0);
        if (rd_e && h == X_OFF + IMG_W - 1 && v == Y_OFF)
            chk("addr_row0_last", 32'(mem_addr), 32'(IMG_W - 1));
        if (rd_e && h == X_OFF && v == Y_OFF + 1)
            chk("addr_row1_first", 32'(mem_addr), 32'(IMG_W));
        if (rd_e && h == X_OFF + IMG_W - 1 && v == Y_OFF + IMG_H - 1)
            chk("addr_last", 32'(mem_addr), 32'(IMG_W * IMG_H - 1));
        if (q.size() == LAT) begin
            o = q.pop_front();
            chk("rgb", 32'(rgb), 32'(o.rgb));
            chk("sync_blank", {28'b0, hsync, vsync, hblank, vblank}, {28'b0, o.hs, o.vs, o.hb, o.vb});
        end
        pos++;
    endtask

    initial begin
        bit did_rst;
        for (int i = 0; i < 2**AW; i++) begin
            mem[i] = 16'($urandom);
            if ($urandom_range(1, 0) == 1) mem[i][14:8] = 7'd10;
        end
        mem[0] = 16'h8A55;
        mem[1] = 16'h0080;
        seg_on  = '0;
        running = 0;
        vb_prev = 1'b1;
        seg_model = '0;
        did_rst = 0;

        // Reset held three cycles mid-frame, released mid-frame
        rst_n = 1'b0;
        pos   = 4 * H_TOT + 7;
        repeat (3) step();
        rst_n = 1'b1;

        for (int k = 0; k < 7 * FR; k++) begin
            if (hof(pos) == 0 && vof(pos) == 0) begin
                seg_on = {$urandom, $urandom, $urandom, $urandom};
                seg_on[10] = ((pos / FR) % 2 == 1);
            end
            // Mid-window toggle must not show until the following frame
            if (hof(pos) == 0 && vof(pos) == Y_OFF + 2)
                seg_on[10] = !seg_on[10];
            if (!did_rst && k >= 4 * FR && hof(pos) == 8 && vof(pos) == 4) begin
                rst_n = 1'b0;
                did_rst = 1;
            end else begin
                rst_n = 1'b1;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
